// File: rtl/reg_ce_rr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_ce_rr_arbiter
//
// Purpose:
//   One clock-enabled storage register shared by NREQ producers. A round-robin
//   arbiter picks an owner. The owner may write up to MAX_BURST consecutive
//   words before ownership rotates. Only the accepted word loads the register.
//
// Ports:
//   CLK         rising-edge clock
//   ASYNCRESET  asynchronous active-high reset
//   ReqValid    [NREQ]        requester i presents a word
//   ReqData     [NREQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   ReqReady    [NREQ]        word from requester i accepted this cycle
//                             (combinational, at most one bit set)
//   Out0        [WIDTH]       shared register contents
//   OutValid                  Out0 was loaded on the previous edge
//   OutOwner    [OW]          requester whose word is currently in Out0
//   Busy                      an owner currently holds a burst
// ---------------------------------------------------------------------------
module reg_ce_rr_arbiter #(
    parameter int  WIDTH     = 16,
    parameter int  NREQ      = 4,
    parameter int  MAX_BURST = 4,
    localparam int OW        = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESET,
    input  logic [NREQ-1:0]       ReqValid,
    input  logic [NREQ*WIDTH-1:0] ReqData,
    output logic [NREQ-1:0]       ReqReady,
    output logic [WIDTH-1:0]      Out0,
    output logic                  OutValid,
    output logic [OW-1:0]         OutOwner,
    output logic                  Busy
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic             out_valid_q, out_valid_d;
    logic [OW-1:0]    out_owner_q, out_owner_d;

    logic [WIDTH-1:0] req_word [NREQ];
    logic [NREQ-1:0]  ready_raw;
    logic [OW-1:0]    sel;
    logic [OW-1:0]    search_idx;
    logic             search_hit;
    logic             acc;
    logic [BW:0]      burst_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_word[gi] = ReqData[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Index + 1 modulo NREQ (NREQ need not be a power of two).
    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
        logic [OW:0] nxt;
        nxt = {1'b0, idx} + (OW+1)'(1);
        if (nxt >= (OW+1)'(NREQ)) begin
            nxt = '0;
        end
        return nxt[OW-1:0];
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr_q.
    always_comb begin
        logic [OW:0] cand;
        search_hit = 1'b0;
        search_idx = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (OW+1)'(k);
            if (cand >= (OW+1)'(NREQ)) begin
                cand = cand - (OW+1)'(NREQ);
            end
            if (!search_hit && ReqValid[cand[OW-1:0]]) begin
                search_hit = 1'b1;
                search_idx = cand[OW-1:0];
            end
        end
    end

    // Next-state, grant and register-load logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        ready_raw   = '0;
        sel         = owner_q;
        acc         = 1'b0;
        burst_inc   = {1'b0, burst_cnt_q} + (BW+1)'(1);

        case (state_q)
            IDLE: begin
                if (search_hit) begin
                    sel                 = search_idx;
                    ready_raw[sel]      = 1'b1;
                    acc                 = 1'b1;
                    owner_d             = search_idx;
                    burst_cnt_d         = BW'(1);
                    if (MAX_BURST == 1) begin
                        // Single-word bursts: rotate right away, never own.
                        rr_ptr_d = wrap_inc(search_idx);
                    end else begin
                        state_d = OWN;
                    end
                end
            end
            OWN: begin
                sel                = owner_q;
                ready_raw[owner_q] = ReqValid[owner_q];
                if (ReqValid[owner_q]) begin
                    acc = 1'b1;
                    if (burst_inc == (BW+1)'(MAX_BURST)) begin
                        state_d     = IDLE;
                        rr_ptr_d    = wrap_inc(owner_q);
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_inc[BW-1:0];
                    end
                end else begin
                    // Owner went quiet: give up the rest of the burst.
                    state_d     = IDLE;
                    rr_ptr_d    = wrap_inc(owner_q);
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out0_d      = acc ? req_word[sel] : out0_q;
        out_owner_d = acc ? sel : out_owner_q;
        out_valid_d = acc;
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            out0_q      <= '0;
            out_valid_q <= 1'b0;
            out_owner_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            out0_q      <= out0_d;
            out_valid_q <= out_valid_d;
            out_owner_q <= out_owner_d;
        end
    end

    // Grants are suppressed while reset is held, even though IDLE would
    // otherwise grant combinationally.
    assign ReqReady = ASYNCRESET ? '0 : ready_raw;
    assign Out0     = out0_q;
    assign OutValid = out_valid_q;
    assign OutOwner = out_owner_q;
    assign Busy     = (state_q == OWN);

endmodule
